// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one single-port register-file RAM between a CPU port and a debug port
module regfile_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic take, sel, issue;
  logic cmd_own, cmd_we, last;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata, rdata0_q, rdata1_q;
  logic [RD_LAT-1:0] pv, po;
  // state, command latch on selection and last-served pointer (port 0 wins the first tie)
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cmd_own   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      last      <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take) begin
        cmd_own   <= sel;
        cmd_we    <= sel ? we1 : we0;
        cmd_addr  <= sel ? addr1 : addr0;
        cmd_wdata <= sel ? wdata1 : wdata0;
      end
      if (issue) last <= cmd_own;
    end
  // arbitration and next state: requests are only looked at in IDLE
  always_comb begin
    take      = state == IDLE && (req0 || req1);
    sel       = (req0 && req1) ? (FIXED_PRI != 0 ? 1'b0 : !last) : req1;
    state_nxt = take ? ISSUE : IDLE;
  end
  // RAM drive and grants only in ISSUE; read data bypasses the holding reg on its rvalid cycle
  always_comb begin
    issue     = state == ISSUE;
    gnt0      = issue && !cmd_own;
    gnt1      = issue && cmd_own;
    ram_read  = issue && !cmd_we;
    ram_write = issue && cmd_we;
    ram_addr  = issue ? cmd_addr : '0;
    ram_wdata = issue ? cmd_wdata : '0;
    rvalid0   = pv[RD_LAT-1] && !po[RD_LAT-1];
    rvalid1   = pv[RD_LAT-1] && po[RD_LAT-1];
    rdata0    = rvalid0 ? ram_rdata : rdata0_q;
    rdata1    = rvalid1 ? ram_rdata : rdata1_q;
  end
  // read-return pipe of {valid, owner} and per-port held read data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pv       <= '0;
      po       <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pv <= RD_LAT'({pv, ram_read});
      po <= RD_LAT'({po, cmd_own});
      if (rvalid0) rdata0_q <= ram_rdata;
      if (rvalid1) rdata1_q <= ram_rdata;
    end
endmodule
